// File: rtl/avaliador_ativos.sv
// Active-node table: stores open graph nodes, applies insert/improve/remove commands,
// and on request publishes up to NUM_NA valid nodes that share the minimum priority.
module avaliador_ativos #(
    parameter int ADDR_WIDTH      = 10,
    parameter int DISTANCIA_WIDTH = 6,
    parameter int CUSTO_WIDTH     = 4,
    parameter int NUM_NA          = 4,
    parameter int NUM_ATIVOS      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            lvv_atualizar_in,
    input  logic [ADDR_WIDTH-1:0]           lvv_endereco_in,
    input  logic [CUSTO_WIDTH-1:0]          lvv_menor_vizinho_in,
    input  logic [DISTANCIA_WIDTH-1:0]      lvv_distancia_in,
    input  logic [ADDR_WIDTH-1:0]           lvv_anterior_in,
    input  logic                            lvv_desativar_in,
    input  logic [ADDR_WIDTH-1:0]           lvv_desativar_addr_in,
    input  logic                            cme_buscar_in,
    output logic                            aa_ocupado_out,
    output logic                            aa_pronto_out,
    output logic [NUM_NA-1:0]               aa_aprovado_out,
    output logic [ADDR_WIDTH*NUM_NA-1:0]    aa_endereco_out,
    output logic [ADDR_WIDTH*NUM_NA-1:0]    aa_anterior_data_out,
    output logic [DISTANCIA_WIDTH*NUM_NA-1:0] aa_distancia_out,
    output logic                            aa_vazio_out,
    output logic                            aa_cheio_out,
    output logic                            aa_descartado_out
);

    localparam int IDX_W      = (NUM_ATIVOS > 1) ? $clog2(NUM_ATIVOS) : 1;
    localparam int SLOT_W     = $clog2(NUM_NA + 1);
    localparam int SLOT_IDX_W = (NUM_NA > 1) ? $clog2(NUM_NA) : 1;
    localparam int P_W        = DISTANCIA_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MINIMO,
        ST_SELECIONAR,
        ST_PRONTO
    } estado_t;

    estado_t estado, prox_estado;

    logic [IDX_W-1:0]           indice;
    logic [P_W-1:0]             minimo;
    logic [SLOT_W-1:0]          slot;
    logic [SLOT_IDX_W-1:0]      slot_idx;
    logic [P_W-1:0]             p_atual;
    logic                       ultimo;

    logic [NUM_ATIVOS-1:0]      valido;
    logic [ADDR_WIDTH-1:0]      endereco  [NUM_ATIVOS];
    logic [CUSTO_WIDTH-1:0]     custo     [NUM_ATIVOS];
    logic [DISTANCIA_WIDTH-1:0] distancia [NUM_ATIVOS];
    logic [ADDR_WIDTH-1:0]      anterior  [NUM_ATIVOS];

    logic                       upd_hit, des_hit, livre_ok;
    logic [IDX_W-1:0]           upd_idx, des_idx, livre_idx;
    logic                       mesmo_addr, ins_ativo;
    logic                       escrever_en, novo_en, descartar_en, limpar_en;
    logic [IDX_W-1:0]           escrever_idx;

    // Priority is zero-extended to one extra bit so the sum can never wrap.
    function automatic logic [P_W-1:0] prioridade(
        input logic [DISTANCIA_WIDTH-1:0] d,
        input logic [CUSTO_WIDTH-1:0]     c
    );
        return P_W'(d) + P_W'(c);
    endfunction

    assign p_atual      = prioridade(distancia[indice], custo[indice]);
    assign ultimo       = (indice == IDX_W'(NUM_ATIVOS - 1));
    assign slot_idx     = SLOT_IDX_W'(slot);
    assign aa_vazio_out = ~|valido;
    assign aa_cheio_out = &valido;

    always_comb begin
        prox_estado    = estado;
        aa_ocupado_out = 1'b0;
        aa_pronto_out  = 1'b0;
        case (estado)
            ST_IDLE: begin
                if (cme_buscar_in) prox_estado = ST_MINIMO;
            end
            ST_MINIMO: begin
                aa_ocupado_out = 1'b1;
                if (ultimo) prox_estado = ST_SELECIONAR;
            end
            ST_SELECIONAR: begin
                aa_ocupado_out = 1'b1;
                if (ultimo) prox_estado = ST_PRONTO;
            end
            ST_PRONTO: begin
                aa_pronto_out = 1'b1;
                prox_estado   = ST_IDLE;
            end
            default: prox_estado = ST_IDLE;
        endcase
    end

    // Address lookup and lowest free slot, both taken from the pre-edge table.
    always_comb begin
        upd_hit   = 1'b0;
        upd_idx   = '0;
        des_hit   = 1'b0;
        des_idx   = '0;
        livre_ok  = 1'b0;
        livre_idx = '0;
        for (int i = 0; i < NUM_ATIVOS; i++) begin
            if (!upd_hit && valido[i] && endereco[i] == lvv_endereco_in) begin
                upd_hit = 1'b1;
                upd_idx = IDX_W'(i);
            end
            if (!des_hit && valido[i] && endereco[i] == lvv_desativar_addr_in) begin
                des_hit = 1'b1;
                des_idx = IDX_W'(i);
            end
            if (!livre_ok && !valido[i]) begin
                livre_ok  = 1'b1;
                livre_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        mesmo_addr   = lvv_atualizar_in && lvv_desativar_in &&
                       (lvv_endereco_in == lvv_desativar_addr_in);
        ins_ativo    = !aa_ocupado_out && lvv_atualizar_in && !mesmo_addr;
        escrever_idx = upd_hit ? upd_idx : livre_idx;
        escrever_en  = ins_ativo &&
                       (upd_hit ? (lvv_distancia_in < distancia[upd_idx]) : livre_ok);
        novo_en      = ins_ativo && !upd_hit && livre_ok;
        descartar_en = ins_ativo && !upd_hit && !livre_ok;
        limpar_en    = !aa_ocupado_out && lvv_desativar_in && des_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado               <= ST_IDLE;
            indice               <= '0;
            minimo               <= '1;
            slot                 <= '0;
            valido               <= '0;
            aa_descartado_out    <= 1'b0;
            aa_aprovado_out      <= '0;
            aa_endereco_out      <= '0;
            aa_anterior_data_out <= '0;
            aa_distancia_out     <= '0;
        end else begin
            estado <= prox_estado;
            case (estado)
                ST_IDLE: begin
                    if (cme_buscar_in) begin
                        indice               <= '0;
                        minimo               <= '1;
                        slot                 <= '0;
                        aa_aprovado_out      <= '0;
                        aa_endereco_out      <= '0;
                        aa_anterior_data_out <= '0;
                        aa_distancia_out     <= '0;
                    end
                end
                ST_MINIMO: begin
                    if (valido[indice] && p_atual < minimo) minimo <= p_atual;
                    indice <= indice + IDX_W'(1);
                end
                ST_SELECIONAR: begin
                    // Ties beyond NUM_NA are skipped; lowest table index lands in slot 0.
                    if (valido[indice] && p_atual == minimo && slot < SLOT_W'(NUM_NA)) begin
                        aa_aprovado_out[slot_idx] <= 1'b1;
                        aa_endereco_out[slot_idx*ADDR_WIDTH +: ADDR_WIDTH]           <= endereco[indice];
                        aa_anterior_data_out[slot_idx*ADDR_WIDTH +: ADDR_WIDTH]      <= anterior[indice];
                        aa_distancia_out[slot_idx*DISTANCIA_WIDTH +: DISTANCIA_WIDTH] <= distancia[indice];
                        slot <= slot + SLOT_W'(1);
                    end
                    indice <= indice + IDX_W'(1);
                end
                default: ;
            endcase
            if (novo_en)      valido[escrever_idx] <= 1'b1;
            if (limpar_en)    valido[des_idx]      <= 1'b0;
            if (descartar_en) aa_descartado_out    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (escrever_en) begin
            endereco[escrever_idx]  <= lvv_endereco_in;
            custo[escrever_idx]     <= lvv_menor_vizinho_in;
            distancia[escrever_idx] <= lvv_distancia_in;
            anterior[escrever_idx]  <= lvv_anterior_in;
        end
    end

endmodule

// File: tb/tb_avaliador_ativos.sv
// Directed bench for avaliador_ativos: table commands, minimum-priority search and reset behaviour.
module tb_avaliador_ativos;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lvv_atualizar_in = 1'b0;
    logic [9:0]  lvv_endereco_in = '0;
    logic [3:0]  lvv_menor_vizinho_in = '0;
    logic [5:0]  lvv_distancia_in = '0;
    logic [9:0]  lvv_anterior_in = '0;
    logic        lvv_desativar_in = 1'b0;
    logic [9:0]  lvv_desativar_addr_in = '0;
    logic        cme_buscar_in = 1'b0;
    logic        aa_ocupado_out, aa_pronto_out;
    logic [3:0]  aa_aprovado_out;
    logic [39:0] aa_endereco_out, aa_anterior_data_out;
    logic [23:0] aa_distancia_out;
    logic        aa_vazio_out, aa_cheio_out, aa_descartado_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avaliador_ativos dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .lvv_atualizar_in     (lvv_atualizar_in),
        .lvv_endereco_in      (lvv_endereco_in),
        .lvv_menor_vizinho_in (lvv_menor_vizinho_in),
        .lvv_distancia_in     (lvv_distancia_in),
        .lvv_anterior_in      (lvv_anterior_in),
        .lvv_desativar_in     (lvv_desativar_in),
        .lvv_desativar_addr_in(lvv_desativar_addr_in),
        .cme_buscar_in        (cme_buscar_in),
        .aa_ocupado_out       (aa_ocupado_out),
        .aa_pronto_out        (aa_pronto_out),
        .aa_aprovado_out      (aa_aprovado_out),
        .aa_endereco_out      (aa_endereco_out),
        .aa_anterior_data_out (aa_anterior_data_out),
        .aa_distancia_out     (aa_distancia_out),
        .aa_vazio_out         (aa_vazio_out),
        .aa_cheio_out         (aa_cheio_out),
        .aa_descartado_out    (aa_descartado_out)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observado=%0h esperado=%0h", tag, obs, exp);
        end
    endtask

    task automatic reiniciar();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cmd(input logic upd, input logic [9:0] a, input logic [3:0] c,
                       input logic [5:0] d, input logic [9:0] ant,
                       input logic des, input logic [9:0] da);
        @(negedge clk);
        lvv_atualizar_in      = upd;
        lvv_endereco_in       = a;
        lvv_menor_vizinho_in  = c;
        lvv_distancia_in      = d;
        lvv_anterior_in       = ant;
        lvv_desativar_in      = des;
        lvv_desativar_addr_in = da;
        @(negedge clk);
        lvv_atualizar_in = 1'b0;
        lvv_desativar_in = 1'b0;
    endtask

    task automatic atualizar(input logic [9:0] a, input logic [3:0] c, input logic [5:0] d,
                             input logic [9:0] ant);
        cmd(1'b1, a, c, d, ant, 1'b0, 10'h000);
    endtask

    task automatic desativar(input logic [9:0] a);
        cmd(1'b0, 10'h000, 4'h0, 6'h00, 10'h000, 1'b1, a);
    endtask

    task automatic buscar_inicio();
        @(negedge clk);
        cme_buscar_in = 1'b1;
        @(negedge clk);
        cme_buscar_in = 1'b0;
        chk("ocupado_inicio", 64'(aa_ocupado_out), 64'd1);
    endtask

    // n0 = cycles already elapsed since the start edge (1 right after buscar_inicio)
    task automatic esperar_pronto(input int n0);
        int n;
        n = n0;
        while (!aa_pronto_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("latencia_pronto", 64'(n), 64'd33);
        chk("ocupado_em_pronto", 64'(aa_ocupado_out), 64'd0);
    endtask

    task automatic conferir(input string tag, input logic [3:0] mask, input logic [39:0] ends,
                            input logic [23:0] dists, input logic [39:0] ants);
        chk({tag, "_mask"}, 64'(aa_aprovado_out), 64'(mask));
        chk({tag, "_endereco"}, 64'(aa_endereco_out), 64'(ends));
        chk({tag, "_distancia"}, 64'(aa_distancia_out), 64'(dists));
        chk({tag, "_anterior"}, 64'(aa_anterior_data_out), 64'(ants));
    endtask

    task automatic buscar(input string tag, input logic [3:0] mask, input logic [39:0] ends,
                          input logic [23:0] dists, input logic [39:0] ants);
        buscar_inicio();
        esperar_pronto(1);
        conferir(tag, mask, ends, dists, ants);
    endtask

    initial begin
        logic [9:0] a;
        int pulsos;

        // Reset state and empty-table search
        reiniciar();
        chk("rst_aprovado", 64'(aa_aprovado_out), 64'd0);
        chk("rst_endereco", 64'(aa_endereco_out), 64'd0);
        chk("rst_pronto", 64'(aa_pronto_out), 64'd0);
        chk("rst_ocupado", 64'(aa_ocupado_out), 64'd0);
        chk("rst_vazio", 64'(aa_vazio_out), 64'd1);
        chk("rst_cheio", 64'(aa_cheio_out), 64'd0);
        chk("rst_descartado", 64'(aa_descartado_out), 64'd0);
        buscar("vazio", 4'b0000, 40'h0, 24'h0, 40'h0);

        // Two entries tie at P=5
        atualizar(10'h005, 4'd2, 6'd3, 10'h105);
        chk("vazio_apos_insercao", 64'(aa_vazio_out), 64'd0);
        atualizar(10'h00A, 4'd1, 6'd4, 10'h10A);
        atualizar(10'h00C, 4'd0, 6'd6, 10'h10C);
        atualizar(10'h011, 4'd4, 6'd4, 10'h111);
        buscar("p5", 4'b0011, {10'h0, 10'h0, 10'h00A, 10'h005},
               {6'd0, 6'd0, 6'd4, 6'd3}, {10'h0, 10'h0, 10'h10A, 10'h105});

        // Six ties at P=7: only four fit, then the remaining two
        reiniciar();
        for (int i = 0; i < 6; i++) begin
            a = 10'h040 + 10'(i);
            atualizar(a, 4'(i), 6'(7 - i), 10'h200 + 10'(i));
        end
        buscar("seis_p7", 4'b1111, {10'h043, 10'h042, 10'h041, 10'h040},
               {6'd4, 6'd5, 6'd6, 6'd7}, {10'h203, 10'h202, 10'h201, 10'h200});
        for (int i = 0; i < 4; i++) begin
            a = 10'h040 + 10'(i);
            desativar(a);
        end
        buscar("restantes", 4'b0011, {10'h0, 10'h0, 10'h045, 10'h044},
               {6'd0, 6'd0, 6'd2, 6'd3}, {10'h0, 10'h0, 10'h205, 10'h204});

        // Improve only on strictly smaller distance
        reiniciar();
        atualizar(10'h020, 4'd1, 6'd5, 10'h002);
        atualizar(10'h020, 4'd1, 6'd3, 10'h001);
        atualizar(10'h020, 4'd1, 6'd9, 10'h3FF);
        buscar("melhoria", 4'b0001, {30'h0, 10'h020}, {18'h0, 6'd3}, {30'h0, 10'h001});

        // Full table, dropped insert, same-address atualizar+desativar
        reiniciar();
        for (int i = 0; i < 16; i++) begin
            a = 10'h030 + 10'(i);
            if (i == 0) atualizar(a, 4'd0, 6'd0, 10'h000);
            else        atualizar(a, 4'd4, 6'd6, 10'h000);
        end
        chk("cheio", 64'(aa_cheio_out), 64'd1);
        chk("descartado_antes", 64'(aa_descartado_out), 64'd0);
        atualizar(10'h0FF, 4'd0, 6'd0, 10'h000);
        chk("descartado", 64'(aa_descartado_out), 64'd1);
        cmd(1'b1, 10'h030, 4'd0, 6'd0, 10'h000, 1'b1, 10'h030);
        chk("cheio_apos_remocao", 64'(aa_cheio_out), 64'd0);
        buscar("sem_030", 4'b1111, {10'h034, 10'h033, 10'h032, 10'h031},
               {6'd6, 6'd6, 6'd6, 6'd6}, 40'h0);
        chk("descartado_pegajoso", 64'(aa_descartado_out), 64'd1);

        // Commands issued while the search is busy are ignored
        reiniciar();
        atualizar(10'h050, 4'd2, 6'd2, 10'h123);
        buscar_inicio();
        repeat (4) @(negedge clk);
        cmd(1'b1, 10'h051, 4'd0, 6'd1, 10'h000, 1'b1, 10'h050);
        esperar_pronto(7);
        conferir("ocupado", 4'b0001, {30'h0, 10'h050}, {18'h0, 6'd2}, {30'h0, 10'h123});
        buscar("tabela_intacta", 4'b0001, {30'h0, 10'h050}, {18'h0, 6'd2}, {30'h0, 10'h123});

        // Reset in the middle of a search
        buscar_inicio();
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_meio_ocupado", 64'(aa_ocupado_out), 64'd0);
        chk("rst_meio_vazio", 64'(aa_vazio_out), 64'd1);
        chk("rst_meio_aprovado", 64'(aa_aprovado_out), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulsos = 0;
        repeat (40) begin
            @(negedge clk);
            if (aa_pronto_out) pulsos++;
        end
        chk("rst_meio_sem_pronto", 64'(pulsos), 64'd0);
        chk("rst_meio_ocioso", 64'(aa_ocupado_out), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/avaliador_ativos.md
# avaliador_ativos

Active-node table at the far end of the update interface driven by the neighbour locator: it stores every "active" (open) graph node with its cost, distance and predecessor, applies `atualizar`/`desativar` commands, and on request scans the table to publish up to NUM_NA approved nodes of minimum priority. Its approved outputs feed the neighbour locator's `aa_aprovado/aa_endereco/aa_anterior_data/aa_distancia` inputs, closing the expand loop.

## Interface
- ADDR_WIDTH, 10, node address width
- DISTANCIA_WIDTH, 6, accumulated distance width
- CUSTO_WIDTH, 4, heuristic cost width
- NUM_NA, 4, max approved nodes per search
- NUM_ATIVOS, 16, table entries (power of 2)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- lvv_atualizar_in  in  1  insert/improve request, one-cycle pulse
- lvv_endereco_in  in  ADDR_WIDTH  node to insert/improve
- lvv_menor_vizinho_in  in  CUSTO_WIDTH  heuristic cost
- lvv_distancia_in  in  DISTANCIA_WIDTH  distance from origin
- lvv_anterior_in  in  ADDR_WIDTH  predecessor node
- lvv_desativar_in  in  1  remove request, one-cycle pulse
- lvv_desativar_addr_in  in  ADDR_WIDTH  node to remove
- cme_buscar_in  in  1  start search (sampled in ST_IDLE only)
- aa_ocupado_out  out  1  search in progress; commands ignored
- aa_pronto_out  out  1  one-cycle pulse, approved outputs valid
- aa_aprovado_out  out  NUM_NA  slot valid mask
- aa_endereco_out  out  ADDR_WIDTH*NUM_NA  approved addresses, slot k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- aa_anterior_data_out  out  ADDR_WIDTH*NUM_NA  predecessors, same packing
- aa_distancia_out  out  DISTANCIA_WIDTH*NUM_NA  distances, same packing
- aa_vazio_out  out  1  no valid entry
- aa_cheio_out  out  1  all entries valid
- aa_descartado_out  out  1  sticky: an insert was dropped (table full)

## Operation
- Entry: valido, endereco, custo, distancia, anterior. Priority P = distancia + custo, DISTANCIA_WIDTH+1 bits, zero-extended, no overflow possible.
- Commands applied on the clock edge only when aa_ocupado_out=0; while ocupado they are ignored without error.
- atualizar, address matches valid entry: overwrite custo/distancia/anterior only if new distancia < stored distancia; else no change.
- atualizar, no match, free entry exists: write lowest-index free entry, set valido.
- atualizar, no match, table full: drop, set aa_descartado_out (cleared only by reset).
- desativar: clear valido of matching entry; no match -> no effect.
- Same-cycle atualizar + desativar, same address: desativar wins (entry invalid afterwards, no insert). Different addresses: both applied; a desativar-freed slot is not reusable by the same-cycle insert.
- FSM: ST_IDLE -> (cme_buscar_in) ST_MINIMO -> ST_SELECIONAR -> ST_PRONTO -> ST_IDLE.
- ST_MINIMO: index 0..NUM_ATIVOS-1, one entry/cycle, tracks minimum P over valid entries.
- ST_SELECIONAR: index 0..NUM_ATIVOS-1 again; each valid entry with P == minimum fills next free slot k (lowest table index -> slot 0) until NUM_NA slots filled; further ties are skipped.
- ST_PRONTO: aa_pronto_out=1 one cycle. Approved outputs hold until next search start; cleared (mask and data to 0) on entering ST_MINIMO. Unfilled slots read 0.
- Empty table: scans still run; result mask 0.
- The table is not modified by the search; the consumer removes approved nodes via desativar.

## Timing
- Reset: all outputs 0, all valido 0, state ST_IDLE, scan index 0.
- cme_buscar_in high at edge T (IDLE): aa_ocupado_out=1 cycles T+1..T+2*NUM_ATIVOS; aa_pronto_out=1 at cycle T+2*NUM_ATIVOS+1 with ocupado=0. NUM_ATIVOS=16: pronto 33 cycles after start.
- cme_buscar_in in any non-IDLE state ignored; held high in IDLE after pronto starts a new search next edge.
- Command effects visible in aa_vazio_out/aa_cheio_out on the cycle after the applying edge.
- Reset mid-search: immediate return to ST_IDLE, table cleared, no pronto.

## Test plan
- Reset -> all outputs 0, aa_vazio_out=1; cme_buscar -> pronto after 33 cycles, aa_aprovado_out=0000.
- Insert 0x005(c2,d3), 0x00A(c1,d4), 0x00C(c0,d6), 0x011(c4,d4); search -> mask 0011, slot0=0x005, slot1=0x00A (P=5), dist 3/4.
- Six entries all P=7 -> mask 1111, slots hold the four lowest table indices; desativar those four, search -> remaining two in slots 0,1.
- Insert 0x020 d5 then atualizar 0x020 d3/anterior 0x001 -> overwritten; then d9 -> unchanged (distancia 3, anterior 0x001).
- Fill 16 entries -> aa_cheio_out=1; 17th insert -> dropped, aa_descartado_out=1; atualizar+desativar 0x030 same cycle -> entry absent.
- Command during ocupado -> table unchanged; rst_n low at search cycle 10 -> ST_IDLE, table empty, no pronto pulse.
